sobel_window3x3: RTL
====================

Name: sobel_window3x3

Overview:
Raster-to-window stage directly upstream of the team's Sobel gradient kernel. Accepts one 8-bit pixel per handshake in raster order. Buffers two image lines and presents the full 3x3 neighbourhood p0..p8 as registered outputs, with a valid strobe. Positions p0..p8 match the ones the kernel consumes.

Parameters:
IMG_WIDTH, 64, pixels per line; 3..1024; sets line-buffer depth and column counter wrap.
IMG_HEIGHT, 64, lines per frame; 3..1024; sets row counter wrap.
PIX_W, 8, pixel width in bits.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_pixel is accepted on a clk edge when high; no backpressure
in_pixel  in  PIX_W  raster-order pixel
out_valid  out  1  p0..p8 hold a complete in-frame window (one-cycle strobe)
p0,p1,p2  out  PIX_W each  top row of window (row r-2), columns c-2, c-1, c
p3,p4,p5  out  PIX_W each  middle row (r-1), columns c-2, c-1, c
p6,p7,p8  out  PIX_W each  bottom row (r), columns c-2, c-1, c; p8 = newest pixel

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: col=0, row=0, all window registers 0, out_valid=0.
  - Line-buffer RAM contents are not reset; stale data is never exposed, because of the valid gating below.
- Storage: two line buffers, each IMG_WIDTH x PIX_W.
  - lb1 holds row r-1. lb2 holds row r-2. Both are addressed by col.
- On each accept (in_valid=1):
  - Read lb1[col] and lb2[col].
  - Write lb2[col] <= old lb1[col], and lb1[col] <= in_pixel.
  - Shift the window left by one column: p0<=p1<=p2<=lb2[col], p3<=p4<=p5<=lb1[col], p6<=p7<=p8<=in_pixel.
  - Read-before-write on the same address is required.
- Counters advance only on accept:
  - col increments and wraps IMG_WIDTH-1 -> 0.
  - On the col wrap, row increments and wraps IMG_HEIGHT-1 -> 0, which is the start of the next frame.
- out_valid: registered. High for exactly the cycle after an accept whose pre-increment position satisfied row>=2 and col>=2; 0 otherwise.
  - Latency: 1 clk from accept to window/strobe.
  - Yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes per frame. No border padding.
- Window registers must not hold values mixed across lines. Columns c-2 and c-1 are only trusted when col>=2, which is what the out_valid gating guarantees.
- in_valid=0: counters, window and RAM hold. out_valid=0 on the next cycle.
- Back-to-back frames: no idle cycle needed.
  - Rows 0-1 of a new frame produce no strobes even though the line buffers hold the previous frame.
- rst mid-frame: counters clear. The next accepted pixel is treated as (row 0, col 0). out_valid=0 on the cycle after rst.
- Arithmetic: counters are ceil(log2(IMG_WIDTH)) and ceil(log2(IMG_HEIGHT)) bits, unsigned, and compare against parameter-1 constants.

Optional Feature:
SOBEL_WIN_SOF_EN:
- When defined:
  - Adds input port in_sof (1 bit), meaningful only with in_valid=1.
  - An accept with in_sof=1 is forced to position (row 0, col 0) regardless of the counters. Counters then continue from (0,1).
  - This resynchronises after a dropped pixel.
  - No out_valid strobe results from that accept.
- When undefined: the port is absent and position comes only from the counters and rst.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4, continuous in_valid, pixel = row*16+col -> first out_valid one cycle after the 11th accept (pixel 0x22), with p0..p8 = 00,01,02,10,11,12,20,21,22.
   - Strobes follow 0x23 (window 01..23), 0x32 and 0x33.
   - Exactly 4 strobes per frame.
2. Same stimulus with in_valid deasserted every other cycle -> identical window sequence and strobe count. out_valid never high on a cycle following in_valid=0.
3. Two frames back-to-back, frame 2 pixels = 0x80+row*16+col -> no strobe during frame-2 rows 0-1. First frame-2 window is 80,81,82,90,91,92,A0,A1,A2.
4. Assert rst for one cycle after pixel 0x21 of frame 1, then restart a fresh frame -> out_valid=0 after rst. First strobe comes after the 11th post-reset accept, with values from the new frame only.
5. IMG_WIDTH=3, IMG_HEIGHT=3 -> exactly one strobe per frame, window = the whole image, p8=0x22.
6. With SOBEL_WIN_SOF_EN defined: send 5 pixels, then in_sof=1 with pixel 0x00 and restart the frame -> strobes match scenario 1 exactly.

Source files
------------

// File: rtl/sobel_window3x3.sv
// sobel_window3x3
// ---------------
// Raster-to-window stage that feeds the Sobel gradient kernel. Pixels arrive
// one per accepted cycle in raster order. Two line buffers hold the previous
// two image rows, and a 3x3 shift window presents the neighbourhood p0..p8 to
// the kernel one clock after the accept that completes it.
//
// Window layout (c = column of the newest pixel, r = its row):
//   p0 p1 p2   row r-2, columns c-2, c-1, c
//   p3 p4 p5   row r-1, columns c-2, c-1, c
//   p6 p7 p8   row r,   columns c-2, c-1, c   (p8 = newest pixel)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_pixel is accepted on a clk edge when high (no backpressure)
//   in_pixel   raster-order pixel, PIX_W bits
//   in_sof     (only with SOBEL_WIN_SOF_EN) forces the accept to row 0, col 0
//   out_valid  one-cycle strobe: p0..p8 hold a complete in-frame window
//   p0..p8     window taps, PIX_W bits each
//
// Optional build macro:
//   SOBEL_WIN_SOF_EN  adds the in_sof port for start-of-frame resync after a
//                     dropped pixel. Without it, position comes only from
//                     the counters and rst.

module sobel_window3x3 #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
`ifdef SOBEL_WIN_SOF_EN
    input  logic             in_sof,
`endif
    output logic             out_valid,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // Position counters (advance only on accept)
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2. Not reset; stale
    // contents never reach a strobed window because of the row/col gating.
    logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
    logic [PIX_W-1:0] lb2_q [IMG_WIDTH];

    // 3x3 window, index k drives output pk
    logic [PIX_W-1:0] win_q [9];
    logic             out_vld_q, out_vld_d;

    // Effective position of the pixel being accepted this cycle
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;
    logic             accept;
    logic             win_ok;

    assign accept = in_valid;

    // Start-of-frame forces (0,0); that position can never complete a window,
    // so the strobe is suppressed without any extra term.
    always_comb begin
        pos_col = col_q;
        pos_row = row_q;
`ifdef SOBEL_WIN_SOF_EN
        if (in_sof) begin
            pos_col = '0;
            pos_row = '0;
        end
`endif
    end

    // Asynchronous reads of the old contents at pos_col; the writes below land
    // on the clock edge, which gives read-before-write on the same address.
    assign lb1_rd = lb1_q[pos_col];
    assign lb2_rd = lb2_q[pos_col];

    // Columns c-2 and c-1 only belong to the current line once col >= 2, and
    // rows r-2 and r-1 only belong to this frame once row >= 2.
    assign win_ok = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        out_vld_d = 1'b0;
        if (accept) begin
            out_vld_d = win_ok;
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end
    end

    // Control and window registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            out_vld_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            out_vld_q <= out_vld_d;
            if (accept) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb2_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= in_pixel;
            end
        end
    end

    // Line-buffer update: the row r-1 entry ages into r-2, new pixel becomes r-1
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[pos_col] <= lb1_rd;
            lb1_q[pos_col] <= in_pixel;
        end
    end

    assign out_valid = out_vld_q;
    assign p0 = win_q[0];
    assign p1 = win_q[1];
    assign p2 = win_q[2];
    assign p3 = win_q[3];
    assign p4 = win_q[4];
    assign p5 = win_q[5];
    assign p6 = win_q[6];
    assign p7 = win_q[7];
    assign p8 = win_q[8];

endmodule
